// File: rtl/plintr_pkg.sv
// Shared definitions for the AXI-Lite interrupt controller: register map and response codes.
package plintr_pkg;

  // Register byte offsets
  localparam logic [4:0] GIE_OFF = 5'h00;
  localparam logic [4:0] IER_OFF = 5'h04;
  localparam logic [4:0] ISR_OFF = 5'h08;
  localparam logic [4:0] IAR_OFF = 5'h0C;
  localparam logic [4:0] IPR_OFF = 5'h10;

  // AXI response code
  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } axi_resp_e;

endpackage

// File: rtl/plintr_axil_irq_ctrl_if.sv
// AXI4-Lite bus bundle (no ID, no PROT) with master and slave views.
interface plintr_axil_irq_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  import plintr_pkg::*;

  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  axi_resp_e           bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  axi_resp_e           rresp;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/plintr_src_detect.sv
// One interrupt source: synchroniser chain, polarity normalisation, edge/level event.
module plintr_src_detect #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE        = 1'b1,
  parameter bit ACTIVE_HIGH = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic intr_in,
  output logic evt
);

  logic sync_out;
  logic norm;
  logic prev_q, prev_d;

  if (SYNC_STAGES == 0) begin : g_bypass
    assign sync_out = intr_in;
  end else begin : g_sync
    logic [SYNC_STAGES-1:0] sync_q, sync_d;

    // Shift the raw input one stage deeper per clock
    always_comb sync_d = SYNC_STAGES'({sync_q, intr_in});

    // Synchroniser flops, cleared by reset
    always_ff @(posedge clk) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= sync_d;
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
  end

  // Normalise polarity and derive the event; edge mode compares with last cycle
  always_comb begin
    norm   = ACTIVE_HIGH ? sync_out : ~sync_out;
    prev_d = norm;
    evt    = EDGE ? (norm & ~prev_q) : norm;
  end

  // Previous normalised value for rising-edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) prev_q <= 1'b0;
    else        prev_q <= prev_d;
  end

endmodule

// File: rtl/plintr_axil_irq_ctrl.sv
// AXI4-Lite interrupt controller: latches masked PL interrupt events and drives one irq line.
module plintr_axil_irq_ctrl
  import plintr_pkg::*;
#(
  parameter int                       C_S_AXI_DATA_WIDTH  = 32,
  parameter int                       C_S_AXI_ADDR_WIDTH  = 5,
  parameter int                       C_NUM_OF_INTR       = 1,
  parameter logic [C_NUM_OF_INTR-1:0] C_INTR_SENSITIVITY  = '1,
  parameter logic [C_NUM_OF_INTR-1:0] C_INTR_ACTIVE_STATE = '1,
  parameter bit                       C_IRQ_SENSITIVITY   = 1'b1,
  parameter bit                       C_IRQ_ACTIVE_STATE  = 1'b1,
  parameter int                       C_SYNC_STAGES       = 2
) (
  input  logic                     S_AXI_ACLK,
  input  logic                     S_AXI_ARESETN,
  plintr_axil_irq_ctrl_if.slave    s_axi,
  input  logic [C_NUM_OF_INTR-1:0] intr_in,
  output logic                     irq
);

  localparam int N  = C_NUM_OF_INTR;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam int DW = C_S_AXI_DATA_WIDTH;

  logic          gie_q, gie_d;
  logic [N-1:0]  ier_q, ier_d;
  logic [N-1:0]  isr_q, isr_d;
  logic [N-1:0]  evt;
  logic [N-1:0]  wmask;
  logic [N-1:0]  ack;
  logic          wr_rdy_q, wr_rdy_d;
  logic          bvalid_q, bvalid_d;
  logic          ar_rdy_q, ar_rdy_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          irq_q, irq_d;
  logic          cond_prev_q, cond_prev_d;
  logic          wr_hs, rd_hs, irq_cond;

  // Per-source detectors and the byte-strobe mask bit that covers each source
  for (genvar gi = 0; gi < N; gi++) begin : g_src
    plintr_src_detect #(
      .SYNC_STAGES (C_SYNC_STAGES),
      .EDGE        (C_INTR_SENSITIVITY[gi]),
      .ACTIVE_HIGH (C_INTR_ACTIVE_STATE[gi])
    ) u_src (
      .clk     (S_AXI_ACLK),
      .rst_n   (S_AXI_ARESETN),
      .intr_in (intr_in[gi]),
      .evt     (evt[gi])
    );
    assign wmask[gi] = s_axi.wstrb[gi/8];
  end

  // Bus handshakes, register writes, status latching and irq generation
  always_comb begin
    wr_hs    = wr_rdy_q & s_axi.awvalid & s_axi.wvalid;
    rd_hs    = ar_rdy_q & s_axi.arvalid;
    // Ready pulses for one cycle; blocked while a response is still outstanding
    wr_rdy_d = s_axi.awvalid & s_axi.wvalid & ~bvalid_q & ~wr_rdy_q;
    bvalid_d = wr_hs | (bvalid_q & ~s_axi.bready);
    ar_rdy_d = s_axi.arvalid & ~rvalid_q & ~ar_rdy_q;
    rvalid_d = rd_hs | (rvalid_q & ~s_axi.rready);

    gie_d = gie_q;
    ier_d = ier_q;
    ack   = '0;
    if (wr_hs) begin
      case (s_axi.awaddr)
        AW'(GIE_OFF): if (s_axi.wstrb[0]) gie_d = s_axi.wdata[0];
        AW'(IER_OFF): ier_d = (ier_q & ~wmask) | (s_axi.wdata[N-1:0] & wmask);
        AW'(IAR_OFF): ack = s_axi.wdata[N-1:0] & wmask;
        default: ;
      endcase
    end

    // Set beats clear so an event coinciding with its ack is kept
    isr_d = (isr_q & ~ack) | (evt & ier_q);

    rdata_d = rdata_q;
    if (rd_hs) begin
      case (s_axi.araddr)
        AW'(GIE_OFF): rdata_d = DW'(gie_q);
        AW'(IER_OFF): rdata_d = DW'(ier_q);
        AW'(ISR_OFF): rdata_d = DW'(isr_q);
        AW'(IPR_OFF): rdata_d = DW'(isr_q & ier_q);
        default:      rdata_d = '0;
      endcase
    end

    irq_cond    = gie_q & |(isr_q & ier_q);
    cond_prev_d = irq_cond;
    irq_d       = C_IRQ_SENSITIVITY ? irq_cond : (irq_cond & ~cond_prev_q);
  end

  // State registers; reset abandons any in-flight transaction
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      gie_q       <= 1'b0;
      ier_q       <= '0;
      isr_q       <= '0;
      wr_rdy_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      ar_rdy_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      irq_q       <= 1'b0;
      cond_prev_q <= 1'b0;
    end else begin
      gie_q       <= gie_d;
      ier_q       <= ier_d;
      isr_q       <= isr_d;
      wr_rdy_q    <= wr_rdy_d;
      bvalid_q    <= bvalid_d;
      ar_rdy_q    <= ar_rdy_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      irq_q       <= irq_d;
      cond_prev_q <= cond_prev_d;
    end
  end

  assign s_axi.awready = wr_rdy_q;
  assign s_axi.wready  = wr_rdy_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = RESP_OKAY;
  assign s_axi.arready = ar_rdy_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = RESP_OKAY;
  assign irq           = C_IRQ_ACTIVE_STATE ? irq_q : ~irq_q;

endmodule

// File: tb/tb_plintr_axil_irq_ctrl.sv
// Self-checking bench for plintr_axil_irq_ctrl (4 edge-triggered active-high sources, level irq).
module tb_plintr_axil_irq_ctrl;
  import plintr_pkg::*;

  localparam int NI = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NI-1:0] intr_in;
  logic          irq;
  int            checks = 0;
  int            failures = 0;

  // Reference model state
  logic          gie_m;
  logic [NI-1:0] ier_m;
  logic [NI-1:0] isr_m;

  always #5 clk = ~clk;

  plintr_axil_irq_ctrl_if #(.ADDR_W(5), .DATA_W(32)) axi ();

  plintr_axil_irq_ctrl #(.C_NUM_OF_INTR(NI)) dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .s_axi         (axi),
    .intr_in       (intr_in),
    .irq           (irq)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           output axi_resp_e r);
    int n;
    axi.awaddr = a; axi.wdata = d; axi.wstrb = s;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.bready = 1'b1;
    n = 0;
    while (axi.awready !== 1'b1 && n < 50) begin step(1); n++; end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL wr_accept_timeout: got no awready at addr %h, required within 50 cycles", a);
    end
    step(1);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    n = 0;
    while (axi.bvalid !== 1'b1 && n < 50) begin step(1); n++; end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL wr_resp_timeout: got no bvalid at addr %h, required within 50 cycles", a);
    end
    r = axi.bresp;
    step(1);
    $display("write addr=%h data=%h strb=%h resp=%0d", a, d, s, r);
  endtask

  task automatic axi_read(input logic [4:0] a, output logic [31:0] d, output axi_resp_e r);
    int n;
    axi.araddr = a; axi.arvalid = 1'b1; axi.rready = 1'b1;
    n = 0;
    while (axi.arready !== 1'b1 && n < 50) begin step(1); n++; end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL rd_accept_timeout: got no arready at addr %h, required within 50 cycles", a);
    end
    step(1);
    axi.arvalid = 1'b0;
    n = 0;
    while (axi.rvalid !== 1'b1 && n < 50) begin step(1); n++; end
    if (n >= 50) begin
      checks++; failures++;
      $display("FAIL rd_resp_timeout: got no rvalid at addr %h, required within 50 cycles", a);
    end
    d = axi.rdata; r = axi.rresp;
    step(1);
    axi.rready = 1'b0;
    $display("read  addr=%h data=%h resp=%0d", a, d, r);
  endtask

  task automatic pulse_src(input logic [NI-1:0] p);
    intr_in = p;
    step(1);
    intr_in = '0;
  endtask

  task automatic test_reset();
    logic [4:0]  offs [5];
    logic [31:0] d;
    axi_resp_e   r;
    offs[0] = GIE_OFF; offs[1] = IER_OFF; offs[2] = ISR_OFF; offs[3] = IAR_OFF; offs[4] = IPR_OFF;
    rst_n = 1'b0;
    step(20);
    checks++;
    if (axi.bvalid !== 1'b0 || axi.rvalid !== 1'b0 || axi.awready !== 1'b0 || axi.arready !== 1'b0) begin
      failures++;
      $display("FAIL reset_handshake: got b=%b r=%b aw=%b ar=%b, required all 0",
               axi.bvalid, axi.rvalid, axi.awready, axi.arready);
    end
    rst_n = 1'b1;
    step(1);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq: got %b required 0", irq); end
    for (int i = 0; i < 5; i++) begin
      axi_read(offs[i], d, r);
      checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL reset_reg: addr %h got %h required 0", offs[i], d); end
      checks++;
      if (r !== RESP_OKAY) begin failures++; $display("FAIL reset_rresp: got %0d required 0", r); end
    end
    axi_write(5'h14, 32'hFFFF_FFFF, 4'hF, r);
    checks++;
    if (r !== RESP_OKAY) begin failures++; $display("FAIL unmapped_bresp: got %0d required 0", r); end
    gie_m = 1'b0; ier_m = '0; isr_m = '0;
  endtask

  task automatic test_irq_latency();
    logic [31:0] d;
    axi_resp_e   r;
    axi_write(GIE_OFF, 32'h1, 4'hF, r);
    axi_write(IER_OFF, 32'h1, 4'hF, r);
    gie_m = 1'b1; ier_m = 4'h1;
    pulse_src(4'h1);
    step(2);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL latency_early: got irq %b required 0 at edge 3", irq); end
    step(1);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL latency_edge4: got irq %b required 1", irq); end
    isr_m = 4'h1;
    axi_read(IPR_OFF, d, r);
    checks++;
    if (d !== 32'h1) begin failures++; $display("FAIL ipr_set: got %h required 1", d); end
    axi_read(ISR_OFF, d, r);
    checks++;
    if (d !== 32'h1) begin failures++; $display("FAIL isr_set: got %h required 1", d); end
    axi_write(IAR_OFF, 32'h1, 4'hF, r);
    isr_m = '0;
    axi_read(IPR_OFF, d, r);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL ipr_after_ack: got %h required 0", d); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL irq_after_ack: got %b required 0", irq); end
  endtask

  task automatic test_masked_event();
    logic [31:0] d;
    axi_resp_e   r;
    axi_write(IER_OFF, 32'h0, 4'hF, r);
    ier_m = '0;
    pulse_src(4'h1);
    step(8);
    axi_read(ISR_OFF, d, r);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL masked_isr: got %h required 0", d); end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL masked_irq: got %b required 0", irq); end
    axi_write(IER_OFF, 32'h1, 4'hF, r);
    ier_m = 4'h1;
    step(4);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL masked_not_remembered: got irq %b required 0", irq); end
  endtask

  task automatic test_ack_collision();
    logic [31:0] d;
    axi_resp_e   r;
    pulse_src(4'h1);
    step(6);
    axi_read(ISR_OFF, d, r);
    checks++;
    if (d !== 32'h1) begin failures++; $display("FAIL collision_setup: got ISR %h required 1", d); end
    // Start the ack one cycle after the source pulse so its handshake lands on the event edge
    intr_in = 4'h1;
    step(1);
    intr_in = '0;
    axi_write(IAR_OFF, 32'h1, 4'hF, r);
    axi_read(ISR_OFF, d, r);
    checks++;
    if (d !== 32'h1) begin failures++; $display("FAIL collision_isr: got %h required 1", d); end
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL collision_irq: got %b required 1", irq); end
    axi_write(IAR_OFF, 32'h1, 4'hF, r);
    isr_m = '0;
  endtask

  task automatic test_random();
    logic [31:0] d, a;
    logic [3:0]  s, p;
    logic [4:0]  ua;
    axi_resp_e   r;
    for (int it = 0; it < 24; it++) begin
      d = 32'($urandom); s = 4'($urandom_range(0, 15));
      axi_write(IER_OFF, d, s, r);
      if (s[0]) ier_m = d[NI-1:0];
      d = 32'($urandom); s = 4'($urandom_range(0, 15));
      axi_write(GIE_OFF, d, s, r);
      if (s[0]) gie_m = d[0];
      p = 4'($urandom_range(0, 15));
      pulse_src(p);
      isr_m = isr_m | (p & ier_m);
      step(6);
      axi_read(ISR_OFF, d, r);
      checks++;
      if (d !== {28'h0, isr_m}) begin failures++; $display("FAIL rand_isr: it %0d got %h required %h", it, d, isr_m); end
      axi_read(IPR_OFF, d, r);
      checks++;
      if (d !== {28'h0, isr_m & ier_m}) begin
        failures++; $display("FAIL rand_ipr: it %0d got %h required %h", it, d, isr_m & ier_m);
      end
      checks++;
      if (irq !== (gie_m & (|(isr_m & ier_m)))) begin
        failures++; $display("FAIL rand_irq: it %0d got %b required %b", it, irq, gie_m & (|(isr_m & ier_m)));
      end
      a = 32'($urandom); s = 4'($urandom_range(0, 15));
      axi_write(IAR_OFF, a, s, r);
      if (s[0]) isr_m = isr_m & ~a[NI-1:0];
      axi_read(ISR_OFF, d, r);
      checks++;
      if (d !== {28'h0, isr_m}) begin failures++; $display("FAIL rand_ack: it %0d got %h required %h", it, d, isr_m); end
      ua = (it % 4 == 0) ? IAR_OFF : 5'(5'h14 + 4 * $urandom_range(0, 2));
      axi_read(ua, d, r);
      checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL rand_unmapped: addr %h got %h required 0", ua, d); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    axi_resp_e   r;
    int          n;
    axi.awaddr = IER_OFF; axi.wdata = 32'h5; axi.wstrb = 4'hF;
    axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.bready = 1'b0;
    n = 0;
    while (axi.awready !== 1'b1 && n < 20) begin step(1); n++; end
    checks++;
    if (n >= 20) begin failures++; $display("FAIL stall_first_accept: got no awready, required within 20 cycles"); end
    step(1);
    axi.wdata = 32'hA;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (axi.bvalid !== 1'b1 || axi.awready !== 1'b0) begin
        failures++;
        $display("FAIL stall_hold: cycle %0d got bvalid=%b awready=%b required 1/0", i, axi.bvalid, axi.awready);
      end
      step(1);
    end
    axi.bready = 1'b1;
    step(1);
    n = 0;
    while (axi.awready !== 1'b1 && n < 20) begin step(1); n++; end
    checks++;
    if (n >= 20) begin failures++; $display("FAIL stall_second_accept: got no awready, required within 20 cycles"); end
    step(1);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    n = 0;
    while (axi.bvalid !== 1'b1 && n < 20) begin step(1); n++; end
    checks++;
    if (axi.bvalid !== 1'b1 || axi.bresp !== RESP_OKAY) begin
      failures++; $display("FAIL stall_second_resp: got bvalid=%b bresp=%0d required 1/0", axi.bvalid, axi.bresp);
    end
    step(1);
    ier_m = 4'hA;
    axi_read(IER_OFF, d, r);
    checks++;
    if (d !== {28'h0, ier_m}) begin failures++; $display("FAIL stall_ier: got %h required %h", d, ier_m); end
  endtask

  task automatic test_reset_mid_read();
    logic [4:0]  offs [5];
    logic [31:0] d;
    axi_resp_e   r;
    int          n;
    offs[0] = GIE_OFF; offs[1] = IER_OFF; offs[2] = ISR_OFF; offs[3] = IAR_OFF; offs[4] = IPR_OFF;
    axi_write(GIE_OFF, 32'h1, 4'hF, r);
    axi_write(IER_OFF, 32'h1, 4'hF, r);
    pulse_src(4'h1);
    step(6);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL midrd_setup_irq: got %b required 1", irq); end
    axi.araddr = ISR_OFF; axi.arvalid = 1'b1; axi.rready = 1'b0;
    n = 0;
    while (axi.arready !== 1'b1 && n < 20) begin step(1); n++; end
    step(1);
    axi.arvalid = 1'b0;
    checks++;
    if (axi.rvalid !== 1'b1) begin failures++; $display("FAIL midrd_rvalid: got %b required 1", axi.rvalid); end
    step(2);
    rst_n = 1'b0;
    step(1);
    checks++;
    if (axi.rvalid !== 1'b0 || irq !== 1'b0) begin
      failures++; $display("FAIL midrd_reset: got rvalid=%b irq=%b required 0/0", axi.rvalid, irq);
    end
    step(3);
    rst_n = 1'b1;
    step(1);
    gie_m = 1'b0; ier_m = '0; isr_m = '0;
    for (int i = 0; i < 5; i++) begin
      axi_read(offs[i], d, r);
      checks++;
      if (d !== 32'h0) begin failures++; $display("FAIL midrd_reg: addr %h got %h required 0", offs[i], d); end
    end
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL midrd_irq_after: got %b required 0", irq); end
  endtask

  initial begin
    rst_n = 1'b0;
    intr_in = '0;
    axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0;
    axi.bready = 1'b0; axi.araddr = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;
    gie_m = 1'b0; ier_m = '0; isr_m = '0;
    test_reset();
    test_irq_latency();
    test_masked_event();
    test_ack_collision();
    test_random();
    test_back_to_back();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
